// File: rtl/pong_game_fsm.sv
// pong_game_fsm
// Top-level game sequencer for pong. Tracks the game state shared by the pad
// controllers and the ball logic. It also keeps both score counters, times the
// pause after each point and issues a one-cycle ball re-launch strobe.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   timing_tick_i  one-cycle frame strobe (same tick the pads use)
//   start_btn_i    raw asynchronous start button, active high
//   miss_left_i    one-cycle pulse: ball passed left edge, right player scores
//   miss_right_i   one-cycle pulse: ball passed right edge, left player scores
//   state_o        START=0, PLAY=1, POINT=2, GAME_OVER=3
//   score_left_o   left player score
//   score_right_o  right player score
//   serve_dir_o    0 = serve toward left, 1 = serve toward right
//   winner_o       0 = left, 1 = right; meaningful only in GAME_OVER
//   ball_reset_o   one-cycle strobe on the first cycle of every PLAY entry
module pong_game_fsm #(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned POINT_TICKS = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timing_tick_i,
  input  logic       start_btn_i,
  input  logic       miss_left_i,
  input  logic       miss_right_i,
  output logic [1:0] state_o,
  output logic [3:0] score_left_o,
  output logic [3:0] score_right_o,
  output logic       serve_dir_o,
  output logic       winner_o,
  output logic       ball_reset_o
);

  typedef enum logic [1:0] {
    ST_START     = 2'd0,
    ST_PLAY      = 2'd1,
    ST_POINT     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam logic [3:0] WinScore = 4'(WIN_SCORE);
  localparam logic [7:0] LastTick = 8'(POINT_TICKS - 1);

  state_e     state_q;
  logic [3:0] score_left_q, score_right_q;
  logic [3:0] score_left_d, score_right_d;
  logic [7:0] tick_cnt_q;
  logic       serve_dir_q, winner_q, ball_reset_q;

  logic start_sync1_q, start_sync2_q, start_sync3_q;
  logic start_press;

  // Two flops resynchronise the button. The third flop holds the previous
  // synchronised level, so a held button yields a single press.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync1_q <= 1'b0;
      start_sync2_q <= 1'b0;
      start_sync3_q <= 1'b0;
    end else begin
      start_sync1_q <= start_btn_i;
      start_sync2_q <= start_sync1_q;
      start_sync3_q <= start_sync2_q;
    end
  end

  assign start_press = start_sync2_q & ~start_sync3_q;

  // Saturating increments; a score never moves past the winning value.
  assign score_left_d  = (score_left_q  < WinScore) ? score_left_q  + 4'd1 : score_left_q;
  assign score_right_d = (score_right_q < WinScore) ? score_right_q + 4'd1 : score_right_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_START;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      tick_cnt_q    <= 8'd0;
      serve_dir_q   <= 1'b1;
      winner_q      <= 1'b0;
      ball_reset_q  <= 1'b0;
    end else begin
      ball_reset_q <= 1'b0;
      case (state_q)
        ST_START: begin
          if (start_press) begin
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            serve_dir_q   <= 1'b1;
            ball_reset_q  <= 1'b1;
            state_q       <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          // miss_left has fixed priority when both edges are missed at once.
          if (miss_left_i) begin
            score_right_q <= score_right_d;
            if (score_right_d == WinScore) begin
              winner_q <= 1'b1;
              state_q  <= ST_GAME_OVER;
            end else begin
              serve_dir_q <= 1'b0;
              tick_cnt_q  <= 8'd0;
              state_q     <= ST_POINT;
            end
          end else if (miss_right_i) begin
            score_left_q <= score_left_d;
            if (score_left_d == WinScore) begin
              winner_q <= 1'b0;
              state_q  <= ST_GAME_OVER;
            end else begin
              serve_dir_q <= 1'b1;
              tick_cnt_q  <= 8'd0;
              state_q     <= ST_POINT;
            end
          end
        end
        ST_POINT: begin
          if (timing_tick_i) begin
            if (tick_cnt_q == LastTick) begin
              ball_reset_q <= 1'b1;
              state_q      <= ST_PLAY;
            end else begin
              tick_cnt_q <= tick_cnt_q + 8'd1;
            end
          end
        end
        ST_GAME_OVER: begin
          // Return to START rather than PLAY so that players get a fresh press.
          if (start_press) begin
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            state_q       <= ST_START;
          end
        end
      endcase
    end
  end

  assign state_o       = state_q;
  assign score_left_o  = score_left_q;
  assign score_right_o = score_right_q;
  assign serve_dir_o   = serve_dir_q;
  assign winner_o      = winner_q;
  assign ball_reset_o  = ball_reset_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// tb_pong_game_fsm
// Directed testbench for pong_game_fsm.
// The stimulus process pushes hand-computed expectations into a scoreboard.
// Each expectation is tagged with the falling edge on which it applies.
// A monitor on the falling clock edge pops due entries and compares them with
// the DUT outputs. It also counts ball_reset pulses.
module tb_pong_game_fsm;

  localparam int F_STATE   = 0;
  localparam int F_SL      = 1;
  localparam int F_SR      = 2;
  localparam int F_SERVE   = 3;
  localparam int F_WIN     = 4;
  localparam int F_BR      = 5;
  localparam int F_BRCOUNT = 6;

  typedef struct {
    int    target;
    string name;
    int    field;
    int    value;
  } expect_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       timingTick, startBtn, missLeft, missRight;
  logic [1:0] stateOut;
  logic [3:0] scoreLeft, scoreRight;
  logic       serveDir, winner, ballReset;

  expect_t sbQ[$];
  int negCount = 0;
  int brCount  = 0;
  int brExp    = 0;
  int checks   = 0;
  int errors   = 0;
  int actual;

  pong_game_fsm #(.WIN_SCORE(5), .POINT_TICKS(120)) dut (
    .clk          (clk),
    .rst          (rst),
    .timing_tick_i(timingTick),
    .start_btn_i  (startBtn),
    .miss_left_i  (missLeft),
    .miss_right_i (missRight),
    .state_o      (stateOut),
    .score_left_o (scoreLeft),
    .score_right_o(scoreRight),
    .serve_dir_o  (serveDir),
    .winner_o     (winner),
    .ball_reset_o (ballReset)
  );

  always #5 clk = ~clk;

  function automatic int fieldValue(input int field);
    case (field)
      F_STATE:   return int'(stateOut);
      F_SL:      return int'(scoreLeft);
      F_SR:      return int'(scoreRight);
      F_SERVE:   return int'(serveDir);
      F_WIN:     return int'(winner);
      F_BR:      return int'(ballReset);
      default:   return brCount;
    endcase
  endfunction

  // Monitor: sample away from the active edge and retire due expectations.
  always @(negedge clk) begin
    negCount++;
    if (ballReset) brCount++;
    for (int i = 0; i < sbQ.size(); ) begin
      if (sbQ[i].target <= negCount) begin
        checks++;
        actual = fieldValue(sbQ[i].field);
        if (sbQ[i].target < negCount) begin
          errors++;
          $display("[TB] FAIL %s: expectation missed its cycle (target %0d, now %0d)",
                   sbQ[i].name, sbQ[i].target, negCount);
        end else if (actual != sbQ[i].value) begin
          errors++;
          $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                   sbQ[i].name, actual, sbQ[i].value, negCount);
        end
        sbQ.delete(i);
      end else begin
        i++;
      end
    end
  end

  // Drive inputs, let one rising edge sample them, and return 1 time unit later.
  task automatic applyStimulus(input logic btn, input logic tick,
                               input logic ml, input logic mr);
    startBtn   = btn;
    timingTick = tick;
    missLeft   = ml;
    missRight  = mr;
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation on the outputs as they stand after the latest edge.
  task automatic checkOutput(input int field, input int value, input string name);
    expect_t e;
    e.target = negCount + 1;
    e.name   = name;
    e.field  = field;
    e.value  = value;
    sbQ.push_back(e);
  endtask

  task automatic giveTicks(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic releaseBtn();
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    summary();
    $finish;
  end

  initial begin
    rst        = 1'b1;
    startBtn   = 1'b0;
    timingTick = 1'b0;
    missLeft   = 1'b0;
    missRight  = 1'b0;

    // 1: reset and idle
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 0, "reset_state");
    checkOutput(F_SL,    0, "reset_score_left");
    checkOutput(F_SR,    0, "reset_score_right");
    checkOutput(F_SERVE, 1, "reset_serve_dir");
    checkOutput(F_WIN,   0, "reset_winner");
    checkOutput(F_BR,    0, "reset_ball_reset");
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 0, "idle_stays_start");

    // 2: start press moves to PLAY on the third sampling edge
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 0, "start_edge1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 0, "start_edge2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 1, "start_edge3_play");
    checkOutput(F_BR,    1, "start_ball_reset_high");
    brExp++;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 1, "play_held");
    checkOutput(F_BR,    0, "start_ball_reset_low");
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    releaseBtn();
    checkOutput(F_STATE,   1,     "held_btn_single_press");
    checkOutput(F_BRCOUNT, brExp, "ball_reset_count_t2");

    // 3: left scores, POINT pause of exactly POINT_TICKS ticks
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(F_STATE, 2, "miss_right_point");
    checkOutput(F_SL,    1, "miss_right_score_left");
    checkOutput(F_SR,    0, "miss_right_score_right");
    checkOutput(F_SERVE, 1, "miss_right_serve");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    giveTicks(119);
    checkOutput(F_STATE, 2, "point_after_119_ticks");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(F_STATE, 1, "point_after_120_ticks");
    checkOutput(F_BR,    1, "reserve_ball_reset_high");
    brExp++;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(F_BR,    0, "reserve_ball_reset_low");

    // 4: simultaneous misses, then misses and start ignored in POINT
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput(F_STATE, 2, "both_miss_point");
    checkOutput(F_SR,    1, "both_miss_score_right");
    checkOutput(F_SL,    1, "both_miss_score_left");
    checkOutput(F_SERVE, 0, "both_miss_serve");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(F_SL, 1, "point_miss_ignored_left");
    checkOutput(F_SR, 1, "point_miss_ignored_right");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    releaseBtn();
    checkOutput(F_STATE, 2, "point_start_ignored");
    giveTicks(120);
    checkOutput(F_STATE, 1, "point_done_t4");
    brExp++;
    checkOutput(F_BRCOUNT, brExp, "ball_reset_count_t4");

    // 5: left player wins straight from PLAY
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput(F_STATE, 2, "run_point");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      giveTicks(120);
      checkOutput(F_STATE, 1, "run_replay");
      brExp++;
    end
    checkOutput(F_SL, 4, "score_left_four");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(F_STATE, 3, "win_game_over");
    checkOutput(F_SL,    5, "win_score_left");
    checkOutput(F_SR,    1, "win_score_right");
    checkOutput(F_WIN,   0, "win_winner_left");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    giveTicks(3);
    checkOutput(F_STATE, 3, "game_over_held");
    checkOutput(F_SL,    5, "game_over_score_held");
    checkOutput(F_SR,    1, "game_over_miss_ignored");
    checkOutput(F_WIN,   0, "game_over_winner_held");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 3, "restart_edge2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 0, "restart_to_start");
    checkOutput(F_SL,    0, "restart_score_left");
    checkOutput(F_SR,    0, "restart_score_right");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    releaseBtn();
    checkOutput(F_STATE, 0, "restart_no_auto_play");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 1, "second_press_play");
    checkOutput(F_BR,    1, "second_press_ball_reset");
    brExp++;
    releaseBtn();
    checkOutput(F_BRCOUNT, brExp, "ball_reset_count_t5");

    // 6: reset in the middle of a POINT pause
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(F_STATE, 2, "pre_reset_point");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    giveTicks(60);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 0, "midgame_reset_state");
    checkOutput(F_SL,    0, "midgame_reset_score_left");
    checkOutput(F_SR,    0, "midgame_reset_score_right");
    checkOutput(F_SERVE, 1, "midgame_reset_serve");
    rst = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(F_STATE, 1, "post_reset_play");
    brExp++;
    releaseBtn();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(F_STATE, 2, "post_reset_point");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    giveTicks(119);
    checkOutput(F_STATE, 2, "post_reset_119_ticks");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(F_STATE, 1, "post_reset_120_ticks");
    brExp++;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(F_BRCOUNT, brExp, "ball_reset_count_t6");

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    while (sbQ.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL %s: expectation never retired", sbQ[0].name);
      sbQ.delete(0);
    end
    summary();
    $finish;
  end

endmodule
